mvau_axis: RTL and testbench

Next-generation matrix-vector activation unit (MVAU) top level with ready/valid handshakes on input and output, so the block tolerates downstream backpressure. It has an internal input-vector buffer: each activation vector is streamed in once and reused across all NF neuron folds. A runtime-writable weight memory replaces the fixed initialised one. It sits between the sliding-window/input stream and the threshold/activation stage of the FINN dataflow pipeline.

---
 rtl/mvau_axis.sv | 226 ++++++++++++++++++++++
 tb/tb_mvau_axis.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvau_axis.sv
`default_nettype none
// ============================================================================
// mvau_axis : matrix-vector activation unit with ready/valid streams, an
//             input-vector reuse buffer and a runtime-writable weight memory.
// Rev 1.0
// ============================================================================
module mvau_axis #(
    parameter int SIMD       = 2,
    parameter int PE         = 2,
    parameter int MatrixW    = 4,
    parameter int MatrixH    = 4,
    parameter int TSrcI      = 4,
    parameter int TW         = 4,
    parameter int TDstI      = 16,
    parameter int SIGNED     = 1,
    parameter int WMEM_DEPTH = (MatrixW / SIMD) * (MatrixH / PE),
    localparam int WA        = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIMD*TSrcI-1:0] in_data,
    input  logic                  in_v,
    output logic                  in_rdy,
    output logic [PE*TDstI-1:0]   out_data,
    output logic                  out_v,
    input  logic                  out_rdy,
    input  logic                  wgt_we,
    input  logic [WA-1:0]         wgt_addr,
    input  logic [PE*SIMD*TW-1:0] wgt_data,
    output logic                  busy
);

    localparam int SF  = MatrixW / SIMD;
    localparam int NF  = MatrixH / PE;
    localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
    localparam int PW  = TSrcI + TW + 2;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        REUSE = 1'b1
    } state_t;

    typedef logic signed [TDstI-1:0] acc_t;

    state_t               state_q, state_d;
    logic [SFW-1:0]       sf_q, sf_d;
    logic [NFW-1:0]       nf_q, nf_d;

    logic [SIMD*TSrcI-1:0] ibuf_q [SF];
    logic [PE*SIMD*TW-1:0] wmem_q [WMEM_DEPTH];

    logic                  s1_v_q, s1_first_q, s1_last_q;
    logic [SIMD*TSrcI-1:0] s1_act_q;
    logic [PE*SIMD*TW-1:0] s1_wgt_q;

    logic                  s2_v_q, s2_first_q, s2_last_q;
    acc_t                  s2_prod_q [PE][SIMD];

    acc_t                  acc_q [PE];
    logic                  out_v_q;
    logic [PE*TDstI-1:0]   out_data_q;

    logic                  w_stall, w_issue, w_sf_last, w_nf_last;
    logic [SIMD*TSrcI-1:0] w_act;
    logic [WA-1:0]         w_waddr;
    acc_t                  w_prod  [PE][SIMD];
    acc_t                  w_sum   [PE];
    acc_t                  w_acc_d [PE];

    assign w_stall   = out_v_q & ~out_rdy;
    assign w_sf_last = (sf_q == SFW'(SF - 1));
    assign w_nf_last = (nf_q == NFW'(NF - 1));
    assign w_waddr   = WA'(nf_q * SF + sf_q);
    assign w_act     = (state_q == FILL) ? in_data : ibuf_q[sf_q];

    always_comb begin
        state_d = state_q;
        sf_d    = sf_q;
        nf_d    = nf_q;
        in_rdy  = 1'b0;
        w_issue = 1'b0;
        case (state_q)
            FILL: begin
                in_rdy  = ~w_stall;
                w_issue = in_v & ~w_stall;
                if (w_issue && w_sf_last && (NF > 1)) begin
                    state_d = REUSE;
                end
            end
            REUSE: begin
                w_issue = ~w_stall;
                if (w_issue && w_sf_last && w_nf_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (w_issue) begin
            if (w_sf_last) begin
                sf_d = '0;
                nf_d = w_nf_last ? '0 : nf_q + NFW'(1);
            end else begin
                sf_d = sf_q + SFW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            sf_q    <= '0;
            nf_q    <= '0;
        end else begin
            state_q <= state_d;
            sf_q    <= sf_d;
            nf_q    <= nf_d;
        end
    end

    // Buffer and weight storage carry no reset; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (w_issue && (state_q == FILL)) begin
            ibuf_q[sf_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wgt_we && !busy) begin
            wmem_q[wgt_addr] <= wgt_data;
        end
    end

    // S1: synchronous weight read alongside the registered activation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
        end else if (!w_stall) begin
            s1_v_q <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            s1_act_q   <= w_act;
            s1_wgt_q   <= wmem_q[w_waddr];
            s1_first_q <= (sf_q == '0);
            s1_last_q  <= w_sf_last;
        end
    end

    for (genvar p = 0; p < PE; p++) begin : g_pe
        for (genvar s = 0; s < SIMD; s++) begin : g_simd
            logic [TSrcI-1:0]     w_a;
            logic [TW-1:0]        w_w;
            logic                 w_a_sgn, w_w_sgn;
            logic signed [PW-1:0] w_a_x, w_w_x, w_pr;
            assign w_a     = s1_act_q[s*TSrcI +: TSrcI];
            assign w_w     = s1_wgt_q[(p*SIMD+s)*TW +: TW];
            assign w_a_sgn = (SIGNED != 0) && w_a[TSrcI-1];
            assign w_w_sgn = (SIGNED != 0) && w_w[TW-1];
            assign w_a_x   = {{(PW-TSrcI){w_a_sgn}}, w_a};
            assign w_w_x   = {{(PW-TW){w_w_sgn}}, w_w};
            assign w_pr    = w_a_x * w_w_x;
            assign w_prod[p][s] = acc_t'(w_pr);
        end
    end

    // S2: registered products
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v_q <= 1'b0;
        end else if (!w_stall) begin
            s2_v_q <= s1_v_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            s2_prod_q  <= w_prod;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
        end
    end

    always_comb begin
        for (int p = 0; p < PE; p++) begin
            w_sum[p] = '0;
            for (int s = 0; s < SIMD; s++) begin
                w_sum[p] = w_sum[p] + s2_prod_q[p][s];
            end
            w_acc_d[p] = s2_first_q ? w_sum[p] : acc_q[p] + w_sum[p];
        end
    end

    // S3: accumulator; the output register loads from the same next value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < PE; p++) begin
                acc_q[p] <= '0;
            end
        end else if (!w_stall && s2_v_q) begin
            acc_q <= w_acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v_q    <= 1'b0;
            out_data_q <= '0;
        end else if (!w_stall && s2_v_q && s2_last_q) begin
            out_v_q <= 1'b1;
            for (int p = 0; p < PE; p++) begin
                out_data_q[p*TDstI +: TDstI] <= w_acc_d[p];
            end
        end else if (out_rdy) begin
            out_v_q <= 1'b0;
        end
    end

    assign out_v    = out_v_q;
    assign out_data = out_data_q;
    assign busy     = (state_q != FILL) | (sf_q != '0) | s1_v_q | s2_v_q | out_v_q;

endmodule
`default_nettype wire

// File: tb/tb_mvau_axis.sv
`default_nettype none
// ============================================================================
// tb_mvau_axis : directed bench for mvau_axis at default parameters.
// Rev 1.0
// ============================================================================
module tb_mvau_axis;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_v = 1'b0;
    logic        in_rdy;
    logic [31:0] out_data;
    logic        out_v;
    logic        out_rdy = 1'b1;
    logic        wgt_we = 1'b0;
    logic [1:0]  wgt_addr = '0;
    logic [15:0] wgt_data = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] beats [$];

    mvau_axis dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_v     (in_v),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_v    (out_v),
        .out_rdy  (out_rdy),
        .wgt_we   (wgt_we),
        .wgt_addr (wgt_addr),
        .wgt_data (wgt_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1ns after the rising edge, so a negedge sample sees the handshake the next edge acts on
    always @(negedge clk) begin
        if (out_v && out_rdy) beats.push_back(out_data);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [15:0] w_lo;
        logic [15:0] w_hi;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, output int icyc);
        int n;
        n = 0;
        in_v = 1'b1;
        in_data = d;
        @(negedge clk);
        while (!in_rdy && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("send_in_rdy", {31'b0, in_rdy}, 32'd1);
        icyc = cyc;
        @(posedge clk);
        #1;
        in_v = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int k;
        k = 0;
        while (beats.size() < n && k < 200) begin
            k++;
            @(negedge clk);
        end
        check(name, beats.size(), n);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("idle", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic [15:0] lo, input logic [15:0] hi);
        wait_idle();
        for (int a = 0; a < 4; a++) begin
            wgt_we   = 1'b1;
            wgt_addr = 2'(a);
            wgt_data = (a < 2) ? lo : hi;
            @(posedge clk);
            #1;
        end
        wgt_we = 1'b0;
    endtask

    initial begin
        int ic0, ic1;
        int ic [8];
        logic [4:0] ov, rv;
        logic [31:0] exp_st [8];

        tbl[0] = '{"ones",    16'h1111, 16'h1111, 8'h21, 8'h43, 32'h000A000A, 32'h000A000A};
        tbl[1] = '{"neg",     16'h7777, 16'h7777, 8'h88, 8'h88, 32'hFF20FF20, 32'hFF20FF20};
        tbl[2] = '{"rows",    16'h1100, 16'h3322, 8'h11, 8'h11, 32'h00040000, 32'h000C0008};
        tbl[3] = '{"mixsign", 16'hC32F, 16'h1111, 8'hD5, 8'h7E, 32'hFFF90005, 32'h00070007};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_v",  {31'b0, out_v},  32'd0);
        check("rst_in_rdy", {31'b0, in_rdy}, 32'd1);
        check("rst_busy",   {31'b0, busy},   32'd0);

        for (int i = 0; i < 4; i++) begin
            load_weights(tbl[i].w_lo, tbl[i].w_hi);
            beats.delete();
            send_beat(tbl[i].a0, ic0);
            send_beat(tbl[i].a1, ic1);
            if (i == 0) begin
                // cycles +1..+5 after the last FILL issue
                ov = '0;
                rv = '0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    ov = {ov[3:0], out_v};
                    rv = {rv[3:0], in_rdy};
                end
                check("latency_out_v", {27'b0, ov}, 32'h05);
                check("reuse_in_rdy",  {27'b0, rv}, 32'h07);
            end
            wait_beats(2, $sformatf("%s_count", tbl[i].name));
            check($sformatf("%s_fold0", tbl[i].name), beats[0], tbl[i].exp0);
            check($sformatf("%s_fold1", tbl[i].name), beats[1], tbl[i].exp1);
        end

        // Backpressure with in_v held high, then back-to-back vectors
        load_weights(16'h1111, 16'h1111);
        beats.delete();
        fork
            begin
                send_beat(8'h21, ic[0]);
                send_beat(8'h43, ic[1]);
                send_beat(8'h11, ic[2]);
                send_beat(8'h11, ic[3]);
                send_beat(8'h22, ic[4]);
                send_beat(8'h22, ic[5]);
                send_beat(8'h21, ic[6]);
                send_beat(8'h43, ic[7]);
            end
            begin
                int n;
                logic [31:0] held;
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_v && n < 60);
                out_rdy = 1'b0;
                held = out_data;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check($sformatf("stall_data_%0d", j), out_data, held);
                    check($sformatf("stall_in_rdy_%0d", j), {31'b0, in_rdy}, 32'd0);
                    check($sformatf("stall_out_v_%0d", j), {31'b0, out_v}, 32'd1);
                end
                check("stall_held_value", held, 32'h000A000A);
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_beats(8, "stall_count");
        repeat (10) @(negedge clk);
        check("stall_no_dup", beats.size(), 8);
        exp_st = '{32'h000A000A, 32'h000A000A, 32'h00040004, 32'h00040004,
                   32'h00080008, 32'h00080008, 32'h000A000A, 32'h000A000A};
        for (int j = 0; j < 8; j++) begin
            if (j < beats.size()) check($sformatf("stall_beat_%0d", j), beats[j], exp_st[j]);
        end
        check("thru_b_to_c", ic[4] - ic[2], 4);
        check("thru_c_to_d", ic[6] - ic[4], 4);

        // Reset while in REUSE
        wait_idle();
        beats.delete();
        send_beat(8'h21, ic0);
        send_beat(8'h43, ic1);
        check("busy_in_reuse", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_v",  {31'b0, out_v},  32'd0);
        check("midrst_in_rdy", {31'b0, in_rdy}, 32'd1);
        check("midrst_busy",   {31'b0, busy},   32'd0);
        repeat (8) @(negedge clk);
        check("midrst_no_beat", beats.size(), 0);
        @(posedge clk);
        #1;
        send_beat(8'h21, ic0);
        send_beat(8'h43, ic1);
        wait_beats(2, "postrst_count");
        check("postrst_fold0", beats[0], 32'h000A000A);
        check("postrst_fold1", beats[1], 32'h000A000A);

        // Weight write while busy is dropped; the same write while idle takes effect
        wait_idle();
        beats.delete();
        send_beat(8'h21, ic0);
        wgt_we   = 1'b1;
        wgt_addr = 2'd0;
        wgt_data = 16'h2222;
        in_v     = 1'b1;
        in_data  = 8'h43;
        @(negedge clk);
        check("wr_while_busy", {31'b0, busy}, 32'd1);
        check("wr_beat_rdy",   {31'b0, in_rdy}, 32'd1);
        @(posedge clk);
        #1;
        wgt_we = 1'b0;
        in_v   = 1'b0;
        wait_beats(2, "wbusy_count");
        check("wbusy_fold0", beats[0], 32'h000A000A);
        check("wbusy_fold1", beats[1], 32'h000A000A);

        wait_idle();
        wgt_we   = 1'b1;
        wgt_addr = 2'd0;
        wgt_data = 16'h2222;
        @(posedge clk);
        #1;
        wgt_we = 1'b0;
        beats.delete();
        send_beat(8'h21, ic0);
        send_beat(8'h43, ic1);
        wait_beats(2, "widle_count");
        check("widle_fold0", beats[0], 32'h000D000D);
        check("widle_fold1", beats[1], 32'h000A000A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
